// File: rtl/trace_checker_if.sv
// Golden-entry push port and CPU write-back trace bundle for trace_checker.
// The loader/CPU side uses the master modport; the checker uses the slave modport.
interface trace_checker_if;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic [4:0]  gold_wnum;
  logic [31:0] gold_wdata;
  logic        gold_last;
  logic [31:0] wb_pc;
  logic [3:0]  wb_rf_we;
  logic [4:0]  wb_rf_wnum;
  logic [31:0] wb_rf_wdata;

  modport master (
    output gold_valid, gold_pc, gold_wnum, gold_wdata, gold_last,
    output wb_pc, wb_rf_we, wb_rf_wnum, wb_rf_wdata,
    input  gold_ready
  );

  modport slave (
    input  gold_valid, gold_pc, gold_wnum, gold_wdata, gold_last,
    input  wb_pc, wb_rf_we, wb_rf_wnum, wb_rf_wdata,
    output gold_ready
  );
endinterface

// File: rtl/trace_checker.sv
// Compares CPU register-file commits against a FIFO of golden entries and reports
// the first divergence, a golden underflow, or a retirement stall (watchdog).
module trace_checker #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  trace_checker_if.slave      bus,
  output logic                o_done,
  output logic                o_pass,
  output logic                o_err,
  output logic [1:0]          o_err_code,
  output logic [31:0]         o_err_pc,
  output logic [31:0]         o_err_exp,
  output logic [31:0]         o_err_got,
  output logic [31:0]         o_commit_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAIL, S_DONE} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        last;
  } entry_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  state_t          r_state;
  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [WW-1:0]   r_wdog;
  logic            r_done;
  logic            r_pass;
  logic            r_err;
  logic [1:0]      r_err_code;
  logic [31:0]     r_err_pc;
  logic [31:0]     r_err_exp;
  logic [31:0]     r_err_got;
  logic [31:0]     r_commit_cnt;

  logic            w_run;
  logic            w_full;
  logic            w_empty;
  logic            w_ready;
  logic            w_push;
  logic            w_chk;
  logic            w_pop;
  logic            w_match;
  entry_t          w_head;
  entry_t          w_in;

  assign w_run   = (r_state == S_RUN);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_ready = w_run && !w_full;
  assign w_push  = bus.gold_valid && w_ready;
  assign w_chk   = w_run && (bus.wb_rf_we != 4'b0) && (bus.wb_rf_wnum != 5'd0);
  assign w_pop   = w_chk && !w_empty;
  assign w_head  = r_mem[r_rptr];
  assign w_in    = '{pc: bus.gold_pc, wnum: bus.gold_wnum, wdata: bus.gold_wdata,
                     last: bus.gold_last};

  // Only enabled bytes of the write data take part in the comparison.
  assign w_match = (w_head.pc == bus.wb_pc) && (w_head.wnum == bus.wb_rf_wnum) &&
                   (((w_head.wdata ^ bus.wb_rf_wdata) & byte_mask(bus.wb_rf_we)) == 32'd0);

  assign bus.gold_ready = w_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_wdog       <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'd0;
      r_err_pc     <= 32'd0;
      r_err_exp    <= 32'd0;
      r_err_got    <= 32'd0;
      r_commit_cnt <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_RUN;
        S_RUN: begin
          if (w_push) r_wptr <= r_wptr + AW'(1);
          if (w_pop)  r_rptr <= r_rptr + AW'(1);
          r_count <= r_count + CW'(w_push) - CW'(w_pop);
          // A commit always outranks the watchdog, even in its expiry cycle.
          if (w_chk) begin
            r_wdog <= '0;
            if (w_empty) begin
              r_state    <= S_FAIL;
              r_done     <= 1'b1;
              r_err      <= 1'b1;
              r_err_code <= 2'd2;
              r_err_pc   <= bus.wb_pc;
              r_err_exp  <= 32'd0;
              r_err_got  <= bus.wb_rf_wdata;
            end else if (w_match) begin
              r_commit_cnt <= r_commit_cnt + 32'd1;
              if (w_head.last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_pass  <= 1'b1;
              end
            end else begin
              r_state    <= S_FAIL;
              r_done     <= 1'b1;
              r_err      <= 1'b1;
              r_err_code <= 2'd1;
              r_err_pc   <= bus.wb_pc;
              r_err_exp  <= w_head.wdata;
              r_err_got  <= bus.wb_rf_wdata;
            end
          end else if (r_wdog == WD_LAST) begin
            r_state    <= S_FAIL;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
            r_err_code <= 2'd3;
            r_err_pc   <= 32'd0;
            r_err_exp  <= 32'd0;
            r_err_got  <= 32'd0;
          end else begin
            r_wdog <= r_wdog + WW'(1);
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;
  assign o_err_pc     = r_err_pc;
  assign o_err_exp    = r_err_exp;
  assign o_err_got    = r_err_got;
  assign o_commit_cnt = r_commit_cnt;
endmodule

// File: tb/tb_trace_checker.sv
// Scoreboard bench for trace_checker: commits queue their expected status, a monitor
// compares the registered status one cycle later; a second instance covers the watchdog.
module tb_trace_checker;
  logic clk;
  logic rst;

  typedef struct packed {
    logic [31:0] cnt;
    logic        done;
    logic        pass;
    logic        err;
    logic [1:0]  code;
    logic [31:0] pc;
    logic [31:0] ex;
    logic [31:0] got;
  } exp_t;

  trace_checker_if a ();
  trace_checker_if b ();

  logic        a_done, a_pass, a_err;
  logic [1:0]  a_code;
  logic [31:0] a_pc, a_exp, a_got, a_cnt;
  logic        b_done, b_pass, b_err;
  logic [1:0]  b_code;
  logic [31:0] b_pc, b_exp, b_got, b_cnt;

  trace_checker #(.DEPTH(16), .TIMEOUT(64)) u_a (
    .clk(clk), .rst(rst), .bus(a),
    .o_done(a_done), .o_pass(a_pass), .o_err(a_err), .o_err_code(a_code),
    .o_err_pc(a_pc), .o_err_exp(a_exp), .o_err_got(a_got), .o_commit_cnt(a_cnt)
  );

  trace_checker #(.DEPTH(16), .TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst), .bus(b),
    .o_done(b_done), .o_pass(b_pass), .o_err(b_err), .o_err_code(b_code),
    .o_err_pc(b_pc), .o_err_exp(b_exp), .o_err_got(b_got), .o_commit_cnt(b_cnt)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  logic mon_go = 1'b0;
  exp_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: a commit driven in a cycle is judged on the registered status after that edge.
  initial begin
    logic s;
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk);
      s = mon_go;
      #1;
      if (s) begin
        n_vec++;
        act = '{cnt: a_cnt, done: a_done, pass: a_pass, err: a_err, code: a_code,
                pc: a_pc, ex: a_exp, got: a_got};
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty: got %h expected queued entry", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_bad++;
            $display("FAIL commit_status: got %h expected %h", act, e);
          end
        end
      end
    end
  end

  task automatic wb_idle();
    a.wb_pc = '0; a.wb_rf_we = '0; a.wb_rf_wnum = '0; a.wb_rf_wdata = '0;
    mon_go = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn,
                        input logic [31:0] wd, input exp_t e);
    a.wb_pc = pc; a.wb_rf_we = we; a.wb_rf_wnum = wn; a.wb_rf_wdata = wd;
    mon_go = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    wb_idle();
  endtask

  task automatic set_gold(input logic v, input logic [31:0] pc, input logic [4:0] wn,
                          input logic [31:0] wd, input logic last);
    a.gold_valid = v; a.gold_pc = pc; a.gold_wnum = wn; a.gold_wdata = wd; a.gold_last = last;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd,
                      input logic last);
    check("push_ready", 32'(a.gold_ready), 32'd1);
    set_gold(1'b1, pc, wn, wd, last);
    @(negedge clk);
    set_gold(1'b0, '0, '0, '0, 1'b0);
  endtask

  // Leaves rst low at a negedge; the next edge moves the checker into RUN.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic exp_t mk(input logic [31:0] cnt, input logic done, input logic pass,
                              input logic err, input logic [1:0] code, input logic [31:0] pc,
                              input logic [31:0] ex, input logic [31:0] got);
    return '{cnt: cnt, done: done, pass: pass, err: err, code: code, pc: pc, ex: ex, got: got};
  endfunction

  initial begin
    int pi, po, mcount;
    logic do_push, do_pop, rdy;
    rst = 1'b1;
    set_gold(1'b0, '0, '0, '0, 1'b0);
    wb_idle();
    b.gold_valid = 1'b0; b.gold_pc = '0; b.gold_wnum = '0; b.gold_wdata = '0; b.gold_last = 1'b0;
    b.wb_pc = '0; b.wb_rf_we = '0; b.wb_rf_wnum = '0; b.wb_rf_wdata = '0;

    // Reset state and first-cycle behaviour.
    do_reset();
    check("rst_ready", 32'(a.gold_ready), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_code", 32'(a_code), 32'd0);
    check("rst_cnt", a_cnt, 32'd0);
    @(posedge clk); #1;
    check("run_ready", 32'(a.gold_ready), 32'd1);
    @(negedge clk);

    // Three matching commits back-to-back, last entry gives pass.
    push(32'h1c000000, 5'd1, 32'd1, 1'b0);
    push(32'h1c000004, 5'd2, 32'd2, 1'b0);
    push(32'h1c000008, 5'd3, 32'd3, 1'b1);
    commit(32'h1c000000, 4'hF, 5'd1, 32'd1, mk(1, 0, 0, 0, 0, 0, 0, 0));
    commit(32'h1c000004, 4'hF, 5'd2, 32'd2, mk(2, 0, 0, 0, 0, 0, 0, 0));
    commit(32'h1c000008, 4'hF, 5'd3, 32'd3, mk(3, 1, 1, 0, 0, 0, 0, 0));
    commit(32'h1c00000c, 4'hF, 5'd4, 32'd4, mk(3, 1, 1, 0, 0, 0, 0, 0));
    check("done_ready", 32'(a.gold_ready), 32'd0);

    // Data mismatch latches error details and freezes the counter.
    do_reset();
    @(negedge clk);
    push(32'h1c000000, 5'd1, 32'd1, 1'b0);
    push(32'h1c000004, 5'd2, 32'd6, 1'b1);
    commit(32'h1c000000, 4'hF, 5'd1, 32'd1, mk(1, 0, 0, 0, 0, 0, 0, 0));
    commit(32'h1c000004, 4'hF, 5'd2, 32'd5, mk(1, 1, 0, 1, 1, 32'h1c000004, 6, 5));
    commit(32'h1c000008, 4'hF, 5'd3, 32'd7, mk(1, 1, 0, 1, 1, 32'h1c000004, 6, 5));
    check("fail_ready", 32'(a.gold_ready), 32'd0);

    // Byte-enable masking; ignored commits consume nothing.
    do_reset();
    @(negedge clk);
    push(32'h1c000010, 5'd5, 32'h12345678, 1'b0);
    push(32'h1c000014, 5'd6, 32'hAABBCCDD, 1'b1);
    commit(32'h1c000010, 4'h0, 5'd5, 32'hFFFFFF78, mk(0, 0, 0, 0, 0, 0, 0, 0));
    commit(32'h1c000010, 4'hF, 5'd0, 32'h12345678, mk(0, 0, 0, 0, 0, 0, 0, 0));
    commit(32'h1c000010, 4'h1, 5'd5, 32'hFFFFFF78, mk(1, 0, 0, 0, 0, 0, 0, 0));
    commit(32'h1c000014, 4'hF, 5'd6, 32'hAABBCCDD, mk(2, 1, 1, 0, 0, 0, 0, 0));

    // Fill to full, pop while valid is held, and stream 40 entries through pointer wrap.
    do_reset();
    @(negedge clk);
    pi = 0; po = 0; mcount = 0;
    for (int cyc = 0; cyc < 200 && po < 40; cyc++) begin
      rdy = (mcount < 16);
      check("fifo_ready", 32'(a.gold_ready), 32'(rdy));
      do_push = (pi < 40);
      if (do_push) set_gold(1'b1, 32'h1c000000 + 32'(pi * 4), 5'((pi % 31) + 1),
                            32'hA5A50000 + 32'(pi), pi == 39);
      else set_gold(1'b0, '0, '0, '0, 1'b0);
      do_pop = (mcount > 0) && (mcount == 16 || pi == 40);
      if (do_pop) begin
        a.wb_pc = 32'h1c000000 + 32'(po * 4); a.wb_rf_we = 4'hF;
        a.wb_rf_wnum = 5'((po % 31) + 1); a.wb_rf_wdata = 32'hA5A50000 + 32'(po);
        mon_go = 1'b1;
        exp_q.push_back(mk(32'(po + 1), po == 39, po == 39, 0, 0, 0, 0, 0));
      end else wb_idle();
      @(negedge clk);
      if (do_push && rdy) begin pi++; mcount++; end
      if (do_pop) begin po++; mcount--; end
    end
    set_gold(1'b0, '0, '0, '0, 1'b0);
    wb_idle();
    check("stream_cnt", a_cnt, 32'd40);
    check("stream_pass", 32'(a_pass), 32'd1);

    // Commit against an empty FIFO while an entry is pushed the same cycle.
    do_reset();
    @(negedge clk);
    set_gold(1'b1, 32'h1c000020, 5'd7, 32'h77, 1'b1);
    commit(32'h1c000020, 4'hF, 5'd7, 32'h77, mk(0, 1, 0, 1, 2, 32'h1c000020, 0, 32'h77));
    set_gold(1'b0, '0, '0, '0, 1'b0);

    // Watchdog on the TIMEOUT=8 instance: fails after exactly 8 RUN cycles.
    do_reset();
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check("wdog_quiet", 32'(b_err), 32'd0);
    end
    @(posedge clk); #1;
    check("wdog_code", 32'(b_code), 32'd3);
    check("wdog_done", 32'(b_done), 32'd1);
    check("wdog_pc", b_pc, 32'd0);
    check("wdog_got", b_got, 32'd0);
    check("wdog_a_ok", 32'(a_err), 32'd0);
    @(negedge clk);

    // Mid-run reset discards FIFO contents and clears all status.
    push(32'h1c000000, 5'd1, 32'd1, 1'b0);
    push(32'h1c000004, 5'd2, 32'd2, 1'b0);
    commit(32'h1c000000, 4'hF, 5'd1, 32'd1, mk(1, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_cnt", a_cnt, 32'd0);
    check("mid_ready", 32'(a.gold_ready), 32'd0);
    check("mid_b_err", 32'(b_err), 32'd0);
    check("mid_b_code", 32'(b_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rel_ready", 32'(a.gold_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_ready_up", 32'(a.gold_ready), 32'd1);
    @(negedge clk);
    commit(32'h1c000004, 4'hF, 5'd2, 32'd2, mk(0, 1, 0, 1, 2, 32'h1c000004, 0, 2));

    repeat (2) @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
